logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameters, one per line:
- WIDTH, default 32, operand and result width in bits (1..64).
- DEPTH, default 2, number of pipeline register stages (1..4).
REQ-002 Ports, one per line:
- clk, input, 1, sole clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand set present.
- in_ready, output, 1, unit accepts an operand set this cycle.
- op, input, 3, operation select.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts the result this cycle.
- out, output, WIDTH, result.
- zero, output, 1, result equals 0.
- op_out, output, 3, op code that produced the result.
REQ-003 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset; no other clocks or asynchronous paths.

Function
REQ-004 op encoding SHALL be:
- 000 a&b
- 001 a|b
- 010 a^b
- 011 ~(a|b)
- 100 a&~b
- 101 ~(a^b)
- 110 a
- 111 ~a
REQ-005 The result SHALL be computed combinationally from a, b and op at the input, then carried through DEPTH register stages together with op, a per-stage valid bit and the zero flag.
REQ-006 Global advance signal: adv = !out_valid || out_ready.
REQ-007 in_ready SHALL equal adv, combinationally.
REQ-008 When adv=1, every stage SHALL shift forward one position in the same cycle. Stage 0 loads valid=in_valid together with the computed result, op and zero.
REQ-009 When adv=0, all stage registers SHALL hold their values, including valid bits.
REQ-010 An operand set SHALL be accepted only on a cycle with in_valid=1 and in_ready=1. Operands with in_valid=0 create a bubble, which occupies a stage; bubbles are not collapsed.
REQ-011 out, zero, op_out and out_valid SHALL be driven directly from the last stage's registers.
REQ-012 Latency: an accepted set SHALL appear with out_valid=1 exactly DEPTH cycles after acceptance, provided adv=1 on every intervening cycle. Each cycle with adv=0 adds one cycle.
REQ-013 Throughput SHALL be one result per cycle while out_ready=1.
REQ-014 While out_valid=1 and out_ready=0, out, zero and op_out SHALL remain stable.
REQ-015 Results SHALL leave in the same order as acceptance; none are dropped or duplicated.
REQ-016 zero SHALL be 1 exactly when the result, over all WIDTH bits, equals 0.
REQ-017 Bitwise operations SHALL be exact over WIDTH bits. There are no carries and no width extension.
REQ-018 A result transfer and a new acceptance in the same cycle (out_valid=1, out_ready=1, in_valid=1) SHALL both occur.

Reset
REQ-019 On a clk edge with reset=1, all stage valid bits SHALL clear to 0, and out, zero and op_out SHALL clear to 0.
REQ-020 During reset, in_ready SHALL evaluate to 1 (out_valid=0). Inputs presented in a reset cycle SHALL be discarded.
REQ-021 Reset mid-operation SHALL discard all in-flight results. The first accept after reset releases SHALL follow REQ-012.
REQ-022 Data registers, other than the reset values of REQ-019, are don't-care while their valid bit is 0.

Verification
REQ-023 WIDTH=32, DEPTH=2, out_ready=1:
- Stimulus: accept a=0xF0F0_1234, b=0x0FF0_FFFF, op=000.
- Required: out=0x00F0_1234, zero=0, op_out=000 exactly 2 cycles later.
REQ-024 Same configuration, back-to-back ops 000..111 on 8 consecutive cycles with a=0xAAAA_5555, b=0xFFFF_0000:
- Required outputs on 8 consecutive cycles: 0xAAAA_0000, 0xFFFF_5555, 0x5555_5555, 0x0000_AAAA, 0x0000_5555, 0xAAAA_AAAA, 0xAAAA_5555, 0x5555_AAAA.
REQ-025 Zero flag:
- Stimulus: op=010, a=b=0x1234_5678.
- Required: out=0, zero=1.
REQ-026 Backpressure:
- Stimulus: fill the pipe, then hold out_ready=0 for 5 cycles.
- Required: in_ready=0 and out stable throughout; no loss or reordering after release.
REQ-027 Reset mid-stream:
- Stimulus: assert reset with 2 results in flight.
- Required: next cycle out_valid=0, out=0, in_ready=1; no stale result ever appears.
REQ-028 Sweep configurations:
- WIDTH=8, DEPTH=1 and WIDTH=64, DEPTH=4.
- Random valid/ready toggling with 1000 transactions.
- Results checked against a reference model; required latency DEPTH + stall cycles.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit. The result is computed at the input, then carried
// through DEPTH stall-together stages along with op, the zero flag and a valid bit.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [2:0]       op_out
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef struct packed {
    logic            vld;
    logic            zero;
    logic [OP_W-1:0] op;
    logic [WIDTH-1:0] res;
  } stage_t;

  stage_t stg_q [DEPTH];
  stage_t stg_d [DEPTH];

  logic [WIDTH-1:0] res_c;
  logic             zero_c;
  logic             adv_c;

  // Bitwise function of the incoming operands.
  always_comb begin
    res_c = '0;
    case (op)
      3'b000:  res_c = a & b;
      3'b001:  res_c = a | b;
      3'b010:  res_c = a ^ b;
      3'b011:  res_c = ~(a | b);
      3'b100:  res_c = a & ~b;
      3'b101:  res_c = ~(a ^ b);
      3'b110:  res_c = a;
      default: res_c = ~a;
    endcase
  end

  assign zero_c = (res_c == '0);

  // Whole pipe moves together whenever the last stage is empty or being drained.
  assign adv_c = !stg_q[LAST].vld || out_ready;

  // Stage 0 loads the new operand set (or a bubble); later stages take their predecessor.
  always_comb begin
    stg_d = stg_q;
    if (adv_c) begin
      stg_d[0].vld  = in_valid;
      stg_d[0].zero = zero_c;
      stg_d[0].op   = op;
      stg_d[0].res  = res_c;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stg_d[IDX_W'(i)] = stg_q[IDX_W'(i - 1)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_q <= '{default: '0};
    end else begin
      stg_q <= stg_d;
    end
  end

  assign in_ready  = adv_c;
  assign out_valid = stg_q[LAST].vld;
  assign out       = stg_q[LAST].res;
  assign zero      = stg_q[LAST].zero;
  assign op_out    = stg_q[LAST].op;

endmodule
